// File: rtl/mips_decode_queue_if.sv
// Handshake/bus bundle between fetch, the decode queue and execute.
// The queue uses the slave modport; the fetch/execute side uses master.
interface mips_decode_queue_if #(
  parameter int EXC_CNT_W = 8
);
  logic [31:0]          inst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic                 zero;
  logic [2:0]           alu_op;
  logic                 writeenable;
  logic                 rd_src;
  logic                 alu_src2;
  logic                 except;
  logic [1:0]           control_type;
  logic                 mem_read;
  logic                 word_we;
  logic                 byte_we;
  logic                 byte_load;
  logic                 lui;
  logic                 slt;
  logic [4:0]           rs;
  logic [4:0]           rt;
  logic [4:0]           rd;
  logic [15:0]          imm;
  logic [EXC_CNT_W-1:0] exc_count;

  modport slave (
    input  inst, in_valid, flush, out_ready, zero,
    output in_ready, out_valid, alu_op, writeenable, rd_src, alu_src2, except,
           control_type, mem_read, word_we, byte_we, byte_load, lui, slt,
           rs, rt, rd, imm, exc_count
  );

  modport master (
    output inst, in_valid, flush, out_ready, zero,
    input  in_ready, out_valid, alu_op, writeenable, rd_src, alu_src2, except,
           control_type, mem_read, word_we, byte_we, byte_load, lui, slt,
           rs, rt, rd, imm, exc_count
  );
endinterface

// File: rtl/mips_decode_queue.sv
// MIPS decoder feeding a DEPTH-entry FIFO with flush, late branch resolution
// and a saturating exception counter. Optional macro: DECODE_BYPASS_EN.
module mips_decode_queue #(
  parameter int DEPTH     = 2,
  parameter int EXC_CNT_W = 8
) (
  input logic                    clock,
  input logic                    reset,
  mips_decode_queue_if.slave     bus
);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOR = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_J    = 3'd3,
    BR_JR   = 3'd4
  } br_kind_t;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic        writeenable;
    logic        rd_src;
    logic        alu_src2;
    logic        except;
    logic        mem_read;
    logic        word_we;
    logic        byte_we;
    logic        byte_load;
    logic        lui;
    logic        slt;
    br_kind_t    kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } entry_t;

  entry_t                 r_mem [DEPTH];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [PTR_W:0]         r_count;
  logic [EXC_CNT_W-1:0]   r_excCount;

  entry_t                 w_dec;
  entry_t                 w_head;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_bypass;
  logic                   w_outValid;
  logic                   w_deq;
  logic                   w_deqQueue;
  logic                   w_enq;
  logic [1:0]             w_ctrlType;
  logic                   w_unusedShamt;

  assign w_unusedShamt = ^bus.inst[10:6];

  // Undecodable words leave every control at zero apart from except.
  always_comb begin
    w_dec        = '0;
    w_dec.kind   = BR_NONE;
    w_dec.rs     = bus.inst[25:21];
    w_dec.rt     = bus.inst[20:16];
    w_dec.rd     = bus.inst[15:11];
    w_dec.imm    = bus.inst[15:0];
    case (bus.inst[31:26])
      6'h00: begin
        w_dec.writeenable = 1'b1;
        case (bus.inst[5:0])
          6'h20: w_dec.alu_op = ALU_ADD;
          6'h22: w_dec.alu_op = ALU_SUB;
          6'h24: w_dec.alu_op = ALU_AND;
          6'h25: w_dec.alu_op = ALU_OR;
          6'h27: w_dec.alu_op = ALU_NOR;
          6'h26: w_dec.alu_op = ALU_XOR;
          6'h2a: begin
            w_dec.alu_op = ALU_SLT;
            w_dec.slt    = 1'b1;
          end
          6'h08: begin
            w_dec.writeenable = 1'b0;
            w_dec.kind        = BR_JR;
          end
          default: begin
            w_dec.writeenable = 1'b0;
            w_dec.except      = 1'b1;
          end
        endcase
      end
      6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        w_dec.writeenable = 1'b1;
        w_dec.rd_src      = 1'b1;
        w_dec.alu_src2    = 1'b1;
        case (bus.inst[31:26])
          6'h0c:   w_dec.alu_op = ALU_AND;
          6'h0d:   w_dec.alu_op = ALU_OR;
          6'h0e:   w_dec.alu_op = ALU_XOR;
          6'h0f:   w_dec.lui    = 1'b1;
          default: w_dec.alu_op = ALU_ADD;
        endcase
      end
      6'h04: begin
        w_dec.alu_op = ALU_SUB;
        w_dec.kind   = BR_BEQ;
      end
      6'h05: begin
        w_dec.alu_op = ALU_SUB;
        w_dec.kind   = BR_BNE;
      end
      6'h23, 6'h24: begin
        w_dec.writeenable = 1'b1;
        w_dec.rd_src      = 1'b1;
        w_dec.alu_src2    = 1'b1;
        w_dec.mem_read    = 1'b1;
        w_dec.byte_load   = (bus.inst[31:26] == 6'h24);
      end
      6'h2b: begin
        w_dec.alu_src2 = 1'b1;
        w_dec.word_we  = 1'b1;
      end
      6'h28: begin
        w_dec.alu_src2 = 1'b1;
        w_dec.byte_we  = 1'b1;
      end
      6'h02: w_dec.kind = BR_J;
      default: w_dec.except = 1'b1;
    endcase
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));

`ifdef DECODE_BYPASS_EN
  assign w_bypass = w_empty & bus.in_valid & ~bus.flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_head     = w_bypass ? w_dec : r_mem[r_head];
  assign w_outValid = ~w_empty | w_bypass;
  assign w_deq      = w_outValid & bus.out_ready & ~bus.flush;
  assign w_deqQueue = w_deq & ~w_bypass;
  // A bypassed word that execute takes this cycle never enters the queue.
  assign w_enq      = bus.in_valid & ~w_full & ~bus.flush & ~(w_bypass & bus.out_ready);

  always_ff @(posedge clock) begin
    if (w_enq) r_mem[r_tail] <= w_dec;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq)      r_tail <= r_tail + 1'b1;
      if (w_deqQueue) r_head <= r_head + 1'b1;
      case ({w_enq, w_deqQueue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_excCount <= '0;
    else if (w_deq && w_head.except && (r_excCount != '1)) r_excCount <= r_excCount + 1'b1;
  end

  // Branch direction resolves late, from the zero flag of the head's compare.
  always_comb begin
    w_ctrlType = 2'd0;
    if (w_outValid) begin
      case (w_head.kind)
        BR_BEQ:  w_ctrlType = bus.zero ? 2'd1 : 2'd0;
        BR_BNE:  w_ctrlType = bus.zero ? 2'd0 : 2'd1;
        BR_J:    w_ctrlType = 2'd2;
        BR_JR:   w_ctrlType = 2'd3;
        default: w_ctrlType = 2'd0;
      endcase
    end
  end

  assign bus.in_ready     = ~w_full;
  assign bus.out_valid    = w_outValid;
  assign bus.control_type = w_ctrlType;
  assign bus.exc_count    = r_excCount;
  assign bus.alu_op       = w_outValid ? w_head.alu_op : 3'd0;
  assign bus.writeenable  = w_outValid & w_head.writeenable;
  assign bus.rd_src       = w_outValid & w_head.rd_src;
  assign bus.alu_src2     = w_outValid & w_head.alu_src2;
  assign bus.except       = w_outValid & w_head.except;
  assign bus.mem_read     = w_outValid & w_head.mem_read;
  assign bus.word_we      = w_outValid & w_head.word_we;
  assign bus.byte_we      = w_outValid & w_head.byte_we;
  assign bus.byte_load    = w_outValid & w_head.byte_load;
  assign bus.lui          = w_outValid & w_head.lui;
  assign bus.slt          = w_outValid & w_head.slt;
  assign bus.rs           = w_outValid ? w_head.rs : 5'd0;
  assign bus.rt           = w_outValid ? w_head.rt : 5'd0;
  assign bus.rd           = w_outValid ? w_head.rd : 5'd0;
  assign bus.imm          = w_outValid ? w_head.imm : 16'd0;
endmodule

// File: tb/tb_mips_decode_queue.sv
// Directed bench for mips_decode_queue (DEPTH=2, EXC_CNT_W=2); expectations
// follow DECODE_BYPASS_EN when it is defined.
module tb_mips_decode_queue;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam logic [31:0] I_ADD = 32'h00221820;
  localparam logic [31:0] I_BEQ = 32'h10220004;
  localparam logic [31:0] I_BNE = 32'h14220004;
  localparam logic [31:0] I_W1  = 32'h20410005;
  localparam logic [31:0] I_W2  = 32'h3c030010;
  localparam logic [31:0] I_W3  = 32'h00431025;
  localparam logic [31:0] I_BAD = 32'hfc000000;
  localparam logic [31:0] I_LW  = 32'h8c220010;

`ifdef DECODE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mips_decode_queue_if #(.EXC_CNT_W(2)) bus ();

  mips_decode_queue #(.DEPTH(2), .EXC_CNT_W(2)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] inst, input logic vld,
                               input logic rdy, input logic fl, input logic z);
    bus.inst      = inst;
    bus.in_valid  = vld;
    bus.out_ready = rdy;
    bus.flush     = fl;
    bus.zero      = z;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expExc;
    checks = 0;
    errors = 0;

    // Reset state
    rst_n = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #10;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_exc_count", bus.exc_count, 0);
    checkOutput("rst_except", bus.except, 0);
    checkOutput("rst_ctype", bus.control_type, 0);
    checkOutput("rst_alu_op", bus.alu_op, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // add $3,$1,$2 with one cycle latency
    applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("add_pre_valid", bus.out_valid, BYP);
    step();
    applyStimulus(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("add_valid", bus.out_valid, 1);
    checkOutput("add_alu_op", bus.alu_op, ALU_ADD);
    checkOutput("add_we", bus.writeenable, 1);
    checkOutput("add_rd_src", bus.rd_src, 0);
    checkOutput("add_rs", bus.rs, 1);
    checkOutput("add_rt", bus.rt, 2);
    checkOutput("add_rd", bus.rd, 3);
    checkOutput("add_ctype", bus.control_type, 0);
    checkOutput("add_except", bus.except, 0);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("add_drained", bus.out_valid, 0);

    // beq / bne resolve from zero without a clock edge
    applyStimulus(I_BEQ, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(I_BEQ, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("beq_ctype_z0", bus.control_type, 0);
    checkOutput("beq_alu_op", bus.alu_op, ALU_SUB);
    checkOutput("beq_we", bus.writeenable, 0);
    checkOutput("beq_imm", bus.imm, 4);
    applyStimulus(I_BEQ, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("beq_ctype_z1", bus.control_type, 1);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(I_BNE, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(I_BNE, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bne_ctype_z0", bus.control_type, 1);
    applyStimulus(I_BNE, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bne_ctype_z1", bus.control_type, 0);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("bne_drained", bus.out_valid, 0);

    // Backpressure: three words offered to a two-entry queue
    applyStimulus(I_W1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("fill1_in_ready", bus.in_ready, 1);
    applyStimulus(I_W2, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("fill2_in_ready", bus.in_ready, 0);
    applyStimulus(I_W3, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("full_in_ready", bus.in_ready, 0);
    checkOutput("full_head_imm", bus.imm, 16'h0005);
    checkOutput("full_head_src2", bus.alu_src2, 1);
    checkOutput("full_head_rd_src", bus.rd_src, 1);
    applyStimulus(I_W3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("deq1_in_ready", bus.in_ready, 1);
    checkOutput("deq1_head_lui", bus.lui, 1);
    checkOutput("deq1_head_rt", bus.rt, 3);
    checkOutput("deq1_head_imm", bus.imm, 16'h0010);
    step();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("deq2_valid", bus.out_valid, 1);
    checkOutput("deq2_head_op", bus.alu_op, ALU_OR);
    checkOutput("deq2_head_rd", bus.rd, 2);
    step();
    checkOutput("deq3_empty", bus.out_valid, 0);

    // Flush beats same-cycle enqueue/dequeue and hides a bad head
    applyStimulus(I_BAD, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(I_W2, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(I_W3, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_out_valid", bus.out_valid, 0);
    checkOutput("flush_in_ready", bus.in_ready, 1);
    checkOutput("flush_exc_count", bus.exc_count, 0);

    // Saturating exception counter
    applyStimulus(I_BAD, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      expExc = k - 1 + BYP;
      if (expExc > 3) expExc = 3;
      checkOutput($sformatf("exc_except_%0d", k), bus.except, 1);
      checkOutput($sformatf("exc_we_%0d", k), bus.writeenable, 0);
      checkOutput($sformatf("exc_count_%0d", k), bus.exc_count, expExc);
    end
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("exc_sat", bus.exc_count, 3);
    checkOutput("exc_drained", bus.out_valid, 0);

    // lw: zero-latency with bypass, one cycle without
`ifdef DECODE_BYPASS_EN
    applyStimulus(I_LW, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("lw_valid", bus.out_valid, 1);
    checkOutput("lw_mem_read", bus.mem_read, 1);
    checkOutput("lw_word_we", bus.word_we, 0);
    checkOutput("lw_src2", bus.alu_src2, 1);
    checkOutput("lw_rd_src", bus.rd_src, 1);
    step();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lw_consumed", bus.out_valid, 0);
`else
    applyStimulus(I_LW, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lw_no_comb", bus.out_valid, 0);
    step();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lw_valid", bus.out_valid, 1);
    checkOutput("lw_mem_read", bus.mem_read, 1);
    checkOutput("lw_word_we", bus.word_we, 0);
    checkOutput("lw_src2", bus.alu_src2, 1);
    checkOutput("lw_rd_src", bus.rd_src, 1);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("lw_consumed", bus.out_valid, 0);
`endif

    // Asynchronous reset in mid-cycle
    applyStimulus(I_W1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("arst_pre_valid", bus.out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", bus.out_valid, 0);
    checkOutput("arst_in_ready", bus.in_ready, 1);
    checkOutput("arst_exc_count", bus.exc_count, 0);
    #1 rst_n = 1'b1;
    step();
    checkOutput("arst_stays_empty", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_decode_queue.md
Name: mips_decode_queue

Overview:
- Registered, parametrised successor to the single-cycle `mips_decode`.
- Decodes 32-bit MIPS instruction words into the datapath control bundle and holds them in a DEPTH-entry FIFO between fetch and execute, with valid/ready handshakes on both sides.
- Adds flush for taken branches and jumps, late branch resolution from the ALU `zero` flag, and a saturating exception counter.

Parameters:
- DEPTH, 2, queue entries; power of two, >=2.
- EXC_CNT_W, 8, width of saturating exception counter.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- inst  input  32  instruction word from fetch
- in_valid  input  1  inst is valid
- in_ready  output  1  queue can accept (not full)
- flush  input  1  discard all queued entries
- out_valid  output  1  head entry is valid
- out_ready  input  1  execute consumes head
- zero  input  1  ALU zero flag for head branch
- alu_op  output  3  head ALU op, team ALU_* encoding
- writeenable  output  1  regfile write
- rd_src  output  1  1 = rt is destination (I-type)
- alu_src2  output  1  1 = immediate operand
- except  output  1  undecodable instruction
- control_type  output  2  0 seq, 1 branch, 2 jump, 3 jr
- mem_read, word_we, byte_we, byte_load, lui, slt  output  1 each  memory/lui/slt controls
- rs, rt, rd  output  5 each  register fields of head
- imm  output  16  immediate of head
- exc_count  output  EXC_CNT_W  exceptions retired

Behaviour:
- Reset (async, reset==0): queue empty; out_valid=0; in_ready=1; exc_count=0. All control outputs are 0 while out_valid=0, including except and control_type.
- Enqueue: on a clock edge with in_valid & in_ready & !flush, decode inst and write it at the tail. Decode is combinational before the write and is the same table as the single-cycle decoder:
  - R-type (opcode 0x00): add 20, sub 22, and 24, or 25, nor 27, xor 26, slt 2a, jr 08.
  - I/J-type: addi 08, andi 0c, ori 0d, xori 0e, lui 0f, beq 04, bne 05, lw 23, lbu 24, sw 2b, sb 28, j 02.
  - Any other opcode/funct: except=1; writeenable, word_we, byte_we and mem_read forced 0.
- Dequeue: on a clock edge with out_valid & out_ready & !flush, the head is removed.
- Simultaneous enqueue and dequeue when full:
  - in_ready reflects the registered count only. No ready-through.
  - The enqueue is refused while full even if a dequeue occurs in the same cycle.
- Latency: an instruction accepted at edge N is visible at the head after edge N, provided the queue was empty.
- Head outputs come from the head register, except control_type. control_type is combinational from the stored branch kind and zero:
  - beq: 1 if zero else 0.
  - bne: 1 if !zero else 0.
  - j → 2; jr → 3; all others → 0.
- flush: on a clock edge with flush=1, the queue is emptied.
  - flush has priority over same-cycle enqueue and dequeue; neither occurs.
  - exc_count is not incremented by a flushed head.
- exc_count:
  - Increments when the head is dequeued with except=1.
  - Saturates at 2^EXC_CNT_W-1.
  - Cleared only by reset.
- Pointers: head and tail are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy count is log2(DEPTH)+1 bits.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: when the queue is empty, in_valid=1 and flush=0, the head outputs show the decode of inst combinationally and out_valid=1 (zero-latency).
  - If out_ready=1 in that cycle, the instruction is consumed and not written into the queue.
  - If out_ready=0, it is written into the queue normally.
- Undefined: no combinational path from inst or in_valid to any output; latency is 1 cycle.

Test Plan:
- Reset with inst=0x00221820 (add $3,$1,$2), in_valid=1, then release; pulse 1 cycle → out_valid=1, alu_op=ALU_ADD, writeenable=1, rd_src=0, rd=3, control_type=0.
- Enqueue beq 0x10220004, hold out_ready=0, toggle zero 0→1 → control_type 0→1 with no clock edge. Repeat with bne 0x14220004 → control_type 1→0.
- DEPTH=2, out_ready=0, offer 3 valid words → in_ready=0 after 2 accepts; third word is held by fetch. Then set out_ready=1 → order preserved; third word accepted after the first dequeue.
- Fill 2 entries, assert flush together with in_valid=1 and out_ready=1 → next cycle out_valid=0, in_ready=1, exc_count unchanged.
- EXC_CNT_W=2, retire 5 words with opcode 0x3f → except=1 on each, writeenable=0, exc_count=1,2,3,3,3.
- With DECODE_BYPASS_EN, empty queue, in_valid=1, out_ready=1, inst=0x8c220010 (lw) → same cycle out_valid=1, mem_read=1, word_we=0, alu_src2=1, rd_src=1. Next cycle out_valid=0.
